// File: rtl/usb_rx_pkg.sv
// Shared types and default timing constants for the USB full-speed receive control unit.
// Timing constants assume a 96 MHz core clock sampling a 12 Mbps line.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_RX   = 3'd1,
        SYNC_CHK  = 3'd2,
        DATA_RX   = 3'd3,
        STORE     = 3'd4,
        EOP_WAIT  = 3'd5,
        ERR_DRAIN = 3'd6
    } rcu_state_t;

    localparam logic [7:0] USB_SYNC_BYTE    = 8'h80;
    localparam int         USB_CLKS_PER_BIT = 8;
    localparam int         USB_SAMPLE_PHASE = 3;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit timer: cycle counter producing the sample strobe, plus a bit counter and registered byte-wrap flag.
// Strobe is combinational from count/enable; byte_done_o lags the 8th strobe by one cycle; no backpressure.
module rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_PHASE = USB_SAMPLE_PHASE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       clear_i,
    input  logic       resync_i,
    output logic       shift_enable_o,
    output logic       byte_done_o,
    output logic [2:0] bit_cnt_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          done_q, done_d;
    logic          strobe;

    assign strobe = enable_i && (cnt_q == CW'(SAMPLE_PHASE));

    always_comb begin
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        done_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            bit_d = '0;
        end else if (enable_i) begin
            // A resync edge restarts the bit period but leaves the bit position alone.
            if (resync_i || (cnt_q == CW'(CLKS_PER_BIT - 1))) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            if (strobe) begin
                bit_d  = bit_q + 3'd1;
                done_d = (bit_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bit_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            done_q <= done_d;
        end
    end

    assign shift_enable_o = strobe;
    assign byte_done_o    = done_q;
    assign bit_cnt_o      = bit_q;

endmodule

// File: rtl/usb_rx_rcu.sv
// USB FS receive control unit: SYNC check, per-byte FIFO write strobe, sticky framing error (Moore outputs).
// w_enable fires 2 cycles after a byte's 8th strobe; no backpressure. USB_RX_RESYNC_EN: d_edge realigns bit timer.
module usb_rx_rcu
    import usb_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int         SAMPLE_PHASE = USB_SAMPLE_PHASE,
    parameter logic [7:0] SYNC_BYTE    = USB_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic [7:0] rcv_data,
    output logic       shift_enable,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    rcu_state_t state_q, state_d;
    logic       r_error_q, r_error_d;
    logic       tmr_enable;
    logic       tmr_clear;
    logic       tmr_resync;
    logic       byte_done;
    logic [2:0] bit_cnt;
    logic       eop_sample;

    assign tmr_enable = (state_q == SYNC_RX) || (state_q == SYNC_CHK) || (state_q == DATA_RX) ||
                        (state_q == STORE)   || (state_q == ERR_DRAIN);

`ifdef USB_RX_RESYNC_EN
    assign tmr_resync = d_edge &&
                        ((state_q == SYNC_RX) || (state_q == DATA_RX) || (state_q == ERR_DRAIN));
`else
    assign tmr_resync = 1'b0;
`endif

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_PHASE(SAMPLE_PHASE)
    ) u_timer (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (tmr_enable),
        .clear_i       (tmr_clear),
        .resync_i      (tmr_resync),
        .shift_enable_o(shift_enable),
        .byte_done_o   (byte_done),
        .bit_cnt_o     (bit_cnt)
    );

    assign eop_sample = eop && shift_enable;

    always_comb begin
        state_d   = state_q;
        r_error_d = r_error_q;
        tmr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_edge) begin
                    state_d   = SYNC_RX;
                    r_error_d = 1'b0;
                    tmr_clear = 1'b1;
                end
            end
            SYNC_RX: begin
                if (eop_sample) begin
                    state_d   = ERR_DRAIN;
                    r_error_d = 1'b1;
                end else if (byte_done) begin
                    state_d = SYNC_CHK;
                end
            end
            SYNC_CHK: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_d = DATA_RX;
                end else begin
                    state_d   = ERR_DRAIN;
                    r_error_d = 1'b1;
                end
            end
            DATA_RX: begin
                // SE0 is only a clean end when it lands exactly on a byte boundary.
                if (eop_sample) begin
                    if (bit_cnt == 3'd0) begin
                        state_d = EOP_WAIT;
                    end else begin
                        state_d   = ERR_DRAIN;
                        r_error_d = 1'b1;
                    end
                end else if (byte_done) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                state_d = DATA_RX;
            end
            ERR_DRAIN: begin
                if (eop_sample) begin
                    state_d = EOP_WAIT;
                end
            end
            EOP_WAIT: begin
                if (d_edge) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_error_q <= r_error_d;
        end
    end

    assign rcving   = (state_q != IDLE);
    assign w_enable = (state_q == STORE);
    assign r_error  = r_error_q;

endmodule

// File: tb/tb_usb_rx_rcu.sv
// Testbench for usb_rx_rcu: table-driven and random packets checked cycle by cycle against a strobe-index model.
module tb_usb_rx_rcu;

    localparam int         CPB  = 8;
    localparam int         SP   = 3;
    localparam logic [7:0] SYNC = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d_edge = 1'b0;
    logic       eop = 1'b0;
    logic [7:0] rcv_data = 8'h00;
    logic       shift_enable;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    int n_vec  = 0;
    int n_miss = 0;
    bit model_err = 1'b0;

    always #5 clk = ~clk;

    usb_rx_rcu #(
        .CLKS_PER_BIT(CPB),
        .SAMPLE_PHASE(SP),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_edge      (d_edge),
        .eop         (eop),
        .rcv_data    (rcv_data),
        .shift_enable(shift_enable),
        .rcving      (rcving),
        .w_enable    (w_enable),
        .r_error     (r_error)
    );

    typedef struct {
        logic [7:0] sync;
        int         b;
        int         gap;
        int         exp_writes;
        bit         exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int strobe_cyc(input int s);
        return 1 + SP + s * CPB;
    endfunction

    // One clock cycle: drive inputs just after the edge, then settle at the falling edge.
    task automatic cyc(input logic de, input logic ep, input logic [7:0] rd);
        @(posedge clk);
        #1;
        d_edge   = de;
        eop      = ep;
        rcv_data = rd;
        @(negedge clk);
    endtask

    // Packet: SYNC byte value, SE0 first sampled on strobe b (counted from the first SYNC bit),
    // J edge 'gap' cycles after the line-idle state is reached.
    task automatic run_packet(input logic [7:0] sync, input int b, input int gap, input bit noise,
                              output int writes, output bit err_end);
        int x, t7, t_eop, edge_c, err_c, k, s;
        bit sync_ok, de, exp_se, exp_we, exp_rv, exp_er;
        sync_ok = (sync == SYNC);
        t7      = strobe_cyc(7);
        t_eop   = strobe_cyc(b);
        err_c   = 1 << 30;
        x       = b;
        if (b < 8) begin
            err_c = t_eop + 1;
            x     = b + 1;
        end else if (!sync_ok) begin
            err_c = t7 + 3;
        end else if ((b - 8) % 8 != 0) begin
            err_c = t_eop + 1;
            x     = b + 1;
        end
        edge_c = strobe_cyc(x) + 1 + gap;
        writes = 0;
        for (int c = 0; c <= edge_c + 2; c++) begin
            de = (c == 0) || (c == edge_c) ||
                 (noise && c > 1 && c < t_eop && $urandom_range(0, 15) == 0);
            cyc(de, (c >= t_eop - 1) && (c < edge_c), (c <= t7 + 2) ? sync : 8'($urandom));
            exp_se = (c >= 1 + SP) && (c <= strobe_cyc(x)) && ((c - 1 - SP) % CPB == 0);
            k      = c - 3 - SP;
            s      = k / CPB;
            exp_we = sync_ok && k >= 0 && (k % CPB == 0) && s >= 15 && ((s - 15) % 8 == 0) && s < b;
            exp_rv = (c >= 1) && (c <= edge_c);
            exp_er = (c == 0) ? model_err : (c >= err_c);
            chk("shift_enable", {31'd0, shift_enable}, {31'd0, exp_se});
            chk("w_enable",     {31'd0, w_enable},     {31'd0, exp_we});
            chk("rcving",       {31'd0, rcving},       {31'd0, exp_rv});
            chk("r_error",      {31'd0, r_error},      {31'd0, exp_er});
            if (w_enable === 1'b1) writes++;
        end
        err_end   = r_error;
        model_err = (err_c < (1 << 30));
    endtask

    initial begin
        int         w, t7, e;
        bit         er, noise_en;
        logic [7:0] rs;
        logic [7:0] sy;
        int         b;

`ifdef USB_RX_RESYNC_EN
        noise_en = 1'b0;
`else
        noise_en = 1'b1;
`endif

        tbl[0] = '{8'h80, 24, 3, 2, 1'b0};
        tbl[1] = '{8'h81, 24, 2, 0, 1'b1};
        tbl[2] = '{8'h80, 13, 2, 0, 1'b1};
        tbl[3] = '{8'h80, 16, 1, 1, 1'b0};
        tbl[4] = '{8'h80,  3, 4, 0, 1'b1};
        tbl[5] = '{8'h80,  8, 2, 0, 1'b0};
        tbl[6] = '{8'h80, 29, 1, 2, 1'b1};
        tbl[7] = '{8'h80, 32, 5, 3, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_shift_enable", {31'd0, shift_enable}, 32'd0);
        chk("rst_rcving",       {31'd0, rcving},       32'd0);
        chk("rst_w_enable",     {31'd0, w_enable},     32'd0);
        chk("rst_r_error",      {31'd0, r_error},      32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_rcving",  {31'd0, rcving},  32'd0);
        chk("idle_r_error", {31'd0, r_error}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_packet(tbl[i].sync, tbl[i].b, tbl[i].gap, 1'b0, w, er);
            chk("tbl_writes", w, tbl[i].exp_writes);
            chk("tbl_error", {31'd0, er}, {31'd0, tbl[i].exp_err});
        end

        for (int i = 0; i < 30; i++) begin
            sy = SYNC;
            if ($urandom_range(0, 3) == 0) begin
                rs = 8'($urandom);
                sy = (rs == SYNC) ? 8'h81 : rs;
            end
            b = $urandom_range(0, 40);
            run_packet(sy, b, $urandom_range(1, 5), noise_en, w, er);
            chk("rand_writes", w, (sy == SYNC && b >= 8) ? (b - 8) / 8 : 0);
        end

        // Reset in the middle of a data byte.
        t7 = strobe_cyc(7);
        cyc(1'b1, 1'b0, SYNC);
        for (int c = 1; c <= strobe_cyc(12) + 1; c++) begin
            cyc(1'b0, 1'b0, (c <= t7 + 2) ? SYNC : 8'h5A);
        end
        chk("mid_rcving", {31'd0, rcving}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_shift_enable", {31'd0, shift_enable}, 32'd0);
        chk("rstmid_rcving",       {31'd0, rcving},       32'd0);
        chk("rstmid_w_enable",     {31'd0, w_enable},     32'd0);
        chk("rstmid_r_error",      {31'd0, r_error},      32'd0);
        for (int c = 0; c < 2 * 8 * CPB; c++) begin
            cyc(1'b0, 1'b0, 8'($urandom));
            chk("post_rst_w_enable",     {31'd0, w_enable},     32'd0);
            chk("post_rst_shift_enable", {31'd0, shift_enable}, 32'd0);
            chk("post_rst_rcving",       {31'd0, rcving},       32'd0);
        end
        model_err = 1'b0;
        run_packet(SYNC, 24, 2, 1'b0, w, er);
        chk("after_rst_writes", w, 2);

`ifdef USB_RX_RESYNC_EN
        // An early edge in DATA_RX restarts the bit period.
        cyc(1'b1, 1'b0, SYNC);
        for (int c = 1; c <= strobe_cyc(10); c++) begin
            cyc(1'b0, 1'b0, (c <= t7 + 2) ? SYNC : 8'h3C);
        end
        e = strobe_cyc(10) + 3;
        for (int c = strobe_cyc(10) + 1; c <= e + 1 + SP; c++) begin
            cyc(c == e, 1'b0, 8'h3C);
            chk("resync_shift_enable", {31'd0, shift_enable}, {31'd0, (c == e + 1 + SP)});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_err = 1'b0;
        run_packet(SYNC, 16, 2, 1'b0, w, er);
        chk("resync_after_writes", w, 1);
`else
        e = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
